// File: rtl/fp16_accumulator.sv
// ---------------------------------------------------------------------------
// fp16_accumulator
//
// Sums a stream of binary16 products into a running fp16 sum using
// round-to-nearest-even. FIRST/LAST flags on each valid beat delimit the
// accumulation groups, and the block emits one result per group. A new
// term can be accepted on every cycle.
//
// Handshake: DVI marks a valid beat. There is no ready signal, so every
// beat with DVI=1 is consumed on the rising edge where it is seen. DVO is
// a one-cycle pulse per completed group. S/S_TYPE/CNT are valid while DVO
// is high and keep their value until the next DVO.
//
// Parameters:
//   EN_OUT_FF  1 adds an output register stage after the result register
//
// Ports:
//   CLK     clock, rising edge
//   RST     synchronous reset, active high
//   DVI     product valid
//   FIRST   first term of a group (qualified by DVI)
//   LAST    last term of a group (qualified by DVI)
//   P_TYPE  one-hot class of P: 5 normal, 4 subnormal, 3 zero, 2 inf,
//           1 qNaN, 0 sNaN
//   P       fp16 product
//   DVO     result valid pulse
//   S_TYPE  one-hot class of S (bit 0 is never set)
//   S       fp16 group sum
//   CNT     number of terms in the group, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module fp16_accumulator #(
    parameter bit EN_OUT_FF = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DVI,
    input  logic        FIRST,
    input  logic        LAST,
    input  logic [5:0]  P_TYPE,
    input  logic [15:0] P,
    output logic        DVO,
    output logic [5:0]  S_TYPE,
    output logic [15:0] S,
    output logic [15:0] CNT
);

    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [5:0]  T_NORM  = 6'b100000;
    localparam logic [5:0]  T_SUB   = 6'b010000;
    localparam logic [5:0]  T_ZERO  = 6'b001000;
    localparam logic [5:0]  T_INF   = 6'b000100;
    localparam logic [5:0]  T_QNAN  = 6'b000010;

    // Class of an fp16 encoding; only ever produces the quiet NaN class.
    function automatic logic [5:0] classify(input logic [15:0] v);
        logic [5:0] t;
        if (v[14:10] == 5'h1F)
            t = (v[9:0] != 10'd0) ? T_QNAN : T_INF;
        else if (v[14:10] == 5'h00)
            t = (v[9:0] == 10'd0) ? T_ZERO : T_SUB;
        else
            t = T_NORM;
        return t;
    endfunction

    // Single-cycle fp16 adder with RNE. Operand classes come alongside the
    // encodings so special cases and the hidden bit need no re-decode.
    function automatic logic [15:0] fp16_add(
        input logic [15:0] a,
        input logic [5:0]  a_type,
        input logic [15:0] b,
        input logic [5:0]  b_type
    );
        logic        a_nan, b_nan, a_inf, b_inf;
        logic [4:0]  ex_a, ex_b, ex_big, ex_small, diff;
        logic [10:0] sig_a, sig_b, sig_big, sig_small;
        logic        sign_big;
        logic [27:0] shifted;
        logic [13:0] ext_big, ext_small, norm;
        logic [14:0] sum;
        logic [3:0]  lzc, shamt;
        logic [5:0]  exp_n, exp_f;
        logic        round_up;
        logic [11:0] sig_r;
        logic [9:0]  mant;
        logic [15:0] res;

        a_nan = a_type[1] | a_type[0];
        b_nan = b_type[1] | b_type[0];
        a_inf = a_type[2];
        b_inf = b_type[2];

        // Subnormals and zeros sit at exponent 1 with a clear hidden bit.
        ex_a  = (a_type[4] | a_type[3]) ? 5'd1 : a[14:10];
        ex_b  = (b_type[4] | b_type[3]) ? 5'd1 : b[14:10];
        sig_a = {a_type[5], a[9:0]};
        sig_b = {b_type[5], b[9:0]};

        // Order by magnitude so the subtraction below never goes negative.
        if (a[14:0] >= b[14:0]) begin
            ex_big = ex_a;  sig_big = sig_a;  sign_big = a[15];
            ex_small = ex_b; sig_small = sig_b;
        end else begin
            ex_big = ex_b;  sig_big = sig_b;  sign_big = b[15];
            ex_small = ex_a; sig_small = sig_a;
        end

        // Align with guard/round/sticky in the three low bits.
        diff    = ex_big - ex_small;
        ext_big = {sig_big, 3'b000};
        shifted = 28'd0;
        if (diff >= 5'd14) begin
            ext_small = {13'd0, |sig_small};
        end else begin
            shifted   = {sig_small, 3'b000, 14'd0} >> diff;
            ext_small = {shifted[27:15], shifted[14] | (|shifted[13:0])};
        end

        if (a[15] == b[15])
            sum = {1'b0, ext_big} + {1'b0, ext_small};
        else
            sum = {1'b0, ext_big} - {1'b0, ext_small};

        // Leading zeros counted from the hidden-bit position (bit 13).
        lzc = 4'd14;
        for (int i = 0; i < 14; i++)
            if (sum[i]) lzc = 4'(13 - i);

        // Left shift bounded so the exponent never drops below 1.
        if ({1'b0, lzc} < ex_big)
            shamt = lzc;
        else
            shamt = 4'(ex_big - 5'd1);

        if (sum[14]) begin
            norm  = {sum[14:2], sum[1] | sum[0]};
            exp_n = {1'b0, ex_big} + 6'd1;
        end else begin
            norm  = sum[13:0] << shamt;
            exp_n = {1'b0, ex_big} - {2'b00, shamt};
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        sig_r    = {1'b0, norm[13:3]} + {11'd0, round_up};

        // Rounding carry renormalizes; a clear hidden bit encodes exponent 0.
        if (sig_r[11]) begin
            exp_f = exp_n + 6'd1;
            mant  = sig_r[10:1];
        end else begin
            exp_f = sig_r[10] ? exp_n : 6'd0;
            mant  = sig_r[9:0];
        end

        if (a_nan || b_nan)
            res = QNAN;
        else if (a_inf && b_inf)
            res = (a[15] != b[15]) ? QNAN : a;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        else if (sum == 15'd0)
            res = {a[15] & b[15], 15'd0};
        else if (exp_f >= 6'd31)
            res = {sign_big, 5'h1F, 10'd0};
        else
            res = {sign_big, exp_f[4:0], mant};
        return res;
    endfunction

    logic [15:0] r_acc;
    logic [5:0]  r_acc_type;
    logic        r_active;
    logic [15:0] r_cnt;
    logic        r_dvo;
    logic [15:0] r_s;
    logic [5:0]  r_s_type;
    logic [15:0] r_s_cnt;

    logic [15:0] w_p_canon;
    logic [5:0]  w_p_type_canon;
    logic [15:0] w_sum;
    logic        w_start;
    logic [15:0] w_acc_next;
    logic [5:0]  w_acc_next_type;
    logic [15:0] w_cnt_next;

    always_comb begin
        w_p_canon       = (P_TYPE[1] | P_TYPE[0]) ? QNAN : P;
        w_p_type_canon  = (P_TYPE[1] | P_TYPE[0]) ? T_QNAN : P_TYPE;
        w_sum           = fp16_add(r_acc, r_acc_type, w_p_canon, w_p_type_canon);
        // A beat arriving with no open group starts one even without FIRST.
        w_start         = FIRST | ~r_active;
        w_acc_next      = w_start ? w_p_canon : w_sum;
        w_acc_next_type = classify(w_acc_next);
        if (w_start)
            w_cnt_next = 16'd1;
        else
            w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc      <= 16'd0;
            r_acc_type <= T_ZERO;
            r_active   <= 1'b0;
            r_cnt      <= 16'd0;
            r_dvo      <= 1'b0;
            r_s        <= 16'd0;
            r_s_type   <= T_ZERO;
            r_s_cnt    <= 16'd0;
        end else begin
            r_dvo <= DVI & LAST;
            if (DVI) begin
                r_acc      <= w_acc_next;
                r_acc_type <= w_acc_next_type;
                r_cnt      <= w_cnt_next;
                r_active   <= ~LAST;
                if (LAST) begin
                    r_s      <= w_acc_next;
                    r_s_type <= w_acc_next_type;
                    r_s_cnt  <= w_cnt_next;
                end
            end
        end
    end

    generate
        if (EN_OUT_FF) begin : g_out_ff
            logic        r_o_dvo;
            logic [15:0] r_o_s;
            logic [5:0]  r_o_s_type;
            logic [15:0] r_o_cnt;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_o_dvo    <= 1'b0;
                    r_o_s      <= 16'd0;
                    r_o_s_type <= T_ZERO;
                    r_o_cnt    <= 16'd0;
                end else begin
                    r_o_dvo    <= r_dvo;
                    r_o_s      <= r_s;
                    r_o_s_type <= r_s_type;
                    r_o_cnt    <= r_s_cnt;
                end
            end

            assign DVO    = r_o_dvo;
            assign S      = r_o_s;
            assign S_TYPE = r_o_s_type;
            assign CNT    = r_o_cnt;
        end else begin : g_no_out_ff
            assign DVO    = r_dvo;
            assign S      = r_s;
            assign S_TYPE = r_s_type;
            assign CNT    = r_s_cnt;
        end
    endgenerate

endmodule

// File: tb/tb_fp16_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fp16_accumulator
//
// Drives two instances in parallel (EN_OUT_FF=0 and EN_OUT_FF=1) with the
// same stimulus. The reference model sums group terms as real numbers and
// rounds the exact sum to fp16 by scaling and ties-to-even, which is
// independent of any shift/round hardware structure.
// ---------------------------------------------------------------------------
module tb_fp16_accumulator;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        dvi   = 1'b0;
    logic        first = 1'b0;
    logic        last  = 1'b0;
    logic [5:0]  p_type = 6'b001000;
    logic [15:0] p     = 16'd0;

    logic        dvo0, dvo1;
    logic [5:0]  st0, st1;
    logic [15:0] s0, s1, c0, c1;

    fp16_accumulator #(.EN_OUT_FF(1'b0)) u_dut0 (
        .CLK(clk), .RST(rst), .DVI(dvi), .FIRST(first), .LAST(last),
        .P_TYPE(p_type), .P(p), .DVO(dvo0), .S_TYPE(st0), .S(s0), .CNT(c0)
    );

    fp16_accumulator #(.EN_OUT_FF(1'b1)) u_dut1 (
        .CLK(clk), .RST(rst), .DVI(dvi), .FIRST(first), .LAST(last),
        .P_TYPE(p_type), .P(p), .DVO(dvo1), .S_TYPE(st1), .S(s1), .CNT(c1)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    int pulses0 = 0;
    int pulses1 = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [15:0] h);
        real m;
        if (h[14:10] == 5'd0) m = real'(h[9:0]) * pow2(-24);
        else                  m = real'({1'b1, h[9:0]}) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -m : m;
    endfunction

    function automatic real rne(input real x);
        real f, fr;
        f  = $floor(x);
        fr = x - f;
        if (fr > 0.5) return f + 1.0;
        if (fr < 0.5) return f;
        return (f / 2.0 == $floor(f / 2.0)) ? f : f + 1.0;
    endfunction

    function automatic logic [15:0] from_real(input real x);
        logic sgn;
        real  mag, q;
        int   e, qi;
        sgn = (x < 0.0);
        mag = sgn ? -x : x;
        if (mag < pow2(-14)) begin
            qi = int'(rne(mag * pow2(24)));
            return {sgn, 15'(qi)};
        end
        e = -14;
        while (mag >= pow2(e + 1)) e++;
        q  = rne(mag / pow2(e - 10));
        qi = int'(q);
        if (qi == 2048) begin
            e++;
            qi = 1024;
        end
        if (e > 15) return {sgn, 15'h7C00};
        return {sgn, 5'(e + 15), 10'(qi - 1024)};
    endfunction

    function automatic logic is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
    endfunction

    function automatic logic [5:0] class_of(input logic [15:0] h);
        if (is_nan(h)) return 6'b000010;
        if (is_inf(h)) return 6'b000100;
        if (h[14:0] == 15'd0) return 6'b001000;
        if (h[14:10] == 5'd0) return 6'b010000;
        return 6'b100000;
    endfunction

    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
        real r;
        if (is_nan(a) || is_nan(b)) return 16'h7E00;
        if (is_inf(a) && is_inf(b)) return (a[15] != b[15]) ? 16'h7E00 : a;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        r = to_real(a) + to_real(b);
        if (r == 0.0) return (a == 16'h8000 && b == 16'h8000) ? 16'h8000 : 16'h0000;
        return from_real(r);
    endfunction

    // Model state: open group plus the two output stages.
    logic        m_started = 1'b0;
    logic        m_active  = 1'b0;
    logic [15:0] m_acc     = 16'd0;
    logic [15:0] m_cnt     = 16'd0;
    logic        m1_dvo = 1'b0, m2_dvo = 1'b0;
    logic [15:0] m1_s = 16'd0, m2_s = 16'd0, m1_c = 16'd0, m2_c = 16'd0;
    logic [5:0]  m1_t = 6'b001000, m2_t = 6'b001000;

    task automatic model_step();
        logic [15:0] pc;
        m_started = 1'b1;
        m2_dvo = m1_dvo; m2_s = m1_s; m2_t = m1_t; m2_c = m1_c;
        if (rst) begin
            m_active = 1'b0; m_acc = 16'd0; m_cnt = 16'd0;
            m1_dvo = 1'b0; m1_s = 16'd0; m1_t = 6'b001000; m1_c = 16'd0;
            m2_dvo = 1'b0; m2_s = 16'd0; m2_t = 6'b001000; m2_c = 16'd0;
        end else begin
            m1_dvo = 1'b0;
            if (dvi) begin
                pc = (p_type[1] | p_type[0]) ? 16'h7E00 : p;
                if (first || !m_active) begin
                    m_acc = pc;
                    m_cnt = 16'd1;
                end else begin
                    m_acc = model_add(m_acc, pc);
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                m_active = !last;
                if (last) begin
                    m1_dvo = 1'b1; m1_s = m_acc; m1_t = class_of(m_acc); m1_c = m_cnt;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic beat(input logic r, input logic d, input logic f, input logic l,
                        input logic [5:0] pt, input logic [15:0] pp);
        @(negedge clk);
        rst = r; dvi = d; first = f; last = l; p_type = pt; p = pp;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 1'b0, 6'b001000, 16'd0);
    endtask

    task automatic term(input logic f, input logic l, input logic [15:0] pp);
        beat(1'b0, 1'b1, f, l, class_of(pp), pp);
    endtask

    // Literal expectations for a finished group, checked on both instances
    // and on the model itself.
    task automatic check_lit(input string name, input logic [15:0] s_exp,
                             input logic [5:0] t_exp, input logic [15:0] c_exp);
        #1;
        chk({name, "_s0"}, s0, s_exp);
        chk({name, "_t0"}, {10'd0, st0}, {10'd0, t_exp});
        chk({name, "_c0"}, c0, c_exp);
        chk({name, "_s1"}, s1, s_exp);
        chk({name, "_t1"}, {10'd0, st1}, {10'd0, t_exp});
        chk({name, "_c1"}, c1, c_exp);
        chk({name, "_model_s"}, m1_s, s_exp);
    endtask

    task automatic grp2(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] s_exp, input logic [5:0] t_exp);
        term(1'b1, 1'b0, a);
        term(1'b0, 1'b1, b);
        idle(3);
        check_lit(name, s_exp, t_exp, 16'd2);
    endtask

    task automatic grp3(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] s_exp, input logic [5:0] t_exp);
        term(1'b1, 1'b0, a);
        term(1'b0, 1'b0, b);
        term(1'b0, 1'b1, c);
        idle(3);
        check_lit(name, s_exp, t_exp, 16'd3);
    endtask

    task automatic rand_term(output logic [15:0] pp, output logic [5:0] pt);
        int k;
        logic [4:0] e;
        k = $urandom_range(0, 99);
        if (k < 60)      e = 5'($urandom_range(8, 22));
        else if (k < 75) e = 5'd0;
        else if (k < 97) e = 5'($urandom_range(1, 30));
        else             e = 5'd31;
        pp = {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
        if (k >= 60 && k < 75 && $urandom_range(0, 3) == 0) pp[9:0] = 10'd0;
        if (e == 5'd31 && $urandom_range(0, 1) == 0) pp[9:0] = 10'd0;
        pt = class_of(pp);
        if (pt[1] && $urandom_range(0, 1) == 1) pt = 6'b000001;
    endtask

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        if (m_started) begin
            chk("dvo0", {15'd0, dvo0}, {15'd0, m1_dvo});
            chk("s0",   s0, m1_s);
            chk("t0",   {10'd0, st0}, {10'd0, m1_t});
            chk("c0",   c0, m1_c);
            chk("dvo1", {15'd0, dvo1}, {15'd0, m2_dvo});
            chk("s1",   s1, m2_s);
            chk("t1",   {10'd0, st1}, {10'd0, m2_t});
            chk("c1",   c1, m2_c);
            if (dvo0 === 1'b1) pulses0++;
            if (dvo1 === 1'b1) pulses1++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p0, p1;
        logic [15:0] rp;
        logic [5:0]  rt;

        beat(1'b1, 1'b0, 1'b0, 1'b0, 6'b001000, 16'd0);
        beat(1'b1, 1'b0, 1'b0, 1'b0, 6'b001000, 16'd0);
        #1;
        chk("rst_s0", s0, 16'd0);
        chk("rst_t0", {10'd0, st0}, 16'h0008);
        chk("rst_c0", c0, 16'd0);
        chk("rst_dvo1", {15'd0, dvo1}, 16'd0);

        grp3("sum35", 16'h3C00, 16'h4000, 16'h3800, 16'h4300, 6'b100000);
        grp3("tie_even", 16'h3C00, 16'h1000, 16'h1000, 16'h3C00, 6'b100000);
        grp3("small_first", 16'h1000, 16'h1000, 16'h3C00, 16'h3C01, 6'b100000);
        grp2("overflow", 16'h7BFF, 16'h7BFF, 16'h7C00, 6'b000100);
        grp2("inf_minus_inf", 16'h7C00, 16'hFC00, 16'h7E00, 6'b000010);
        grp2("cancel", 16'h4000, 16'hC000, 16'h0000, 6'b001000);
        grp2("neg_zero", 16'h8000, 16'h8000, 16'h8000, 6'b001000);
        grp2("subnorm", 16'h0001, 16'h0001, 16'h0002, 6'b010000);
        grp2("sub_to_norm", 16'h03FF, 16'h0001, 16'h0400, 6'b100000);

        // sNaN-class term inside a group
        term(1'b1, 1'b0, 16'h3C00);
        beat(1'b0, 1'b1, 1'b0, 1'b0, 6'b000001, 16'h7D00);
        term(1'b0, 1'b1, 16'h3C00);
        idle(3);
        check_lit("snan", 16'h7E00, 6'b000010, 16'd3);

        // FIRST while a group is open restarts it
        term(1'b1, 1'b0, 16'h4000);
        term(1'b1, 1'b1, 16'h3C00);
        idle(3);
        check_lit("restart", 16'h3C00, 6'b100000, 16'd1);

        // four back-to-back single-term groups, with latency checks
        p0 = pulses0; p1 = pulses1;
        term(1'b1, 1'b1, 16'h3C00);
        #1;
        chk("lat_dvo0_first", {15'd0, dvo0}, 16'd1);
        chk("lat_dvo1_first", {15'd0, dvo1}, 16'd0);
        term(1'b1, 1'b1, 16'h4000);
        #1;
        chk("lat_dvo1_second", {15'd0, dvo1}, 16'd1);
        term(1'b1, 1'b1, 16'h4200);
        term(1'b1, 1'b1, 16'h4400);
        idle(1);
        #1;
        chk("lat_dvo0_end", {15'd0, dvo0}, 16'd0);
        chk("lat_dvo1_last", {15'd0, dvo1}, 16'd1);
        idle(3);
        chk("singles_pulses0", 16'(pulses0 - p0), 16'd4);
        chk("singles_pulses1", 16'(pulses1 - p1), 16'd4);
        check_lit("single_last", 16'h4400, 6'b100000, 16'd1);

        // reset mid-group (input on the reset cycle is ignored)
        p0 = pulses0; p1 = pulses1;
        term(1'b1, 1'b0, 16'h3C00);
        term(1'b0, 1'b0, 16'h4000);
        beat(1'b1, 1'b1, 1'b0, 1'b1, 6'b100000, 16'h4000);
        #1;
        chk("midrst_s0", s0, 16'd0);
        chk("midrst_t1", {10'd0, st1}, 16'h0008);
        chk("midrst_c1", c1, 16'd0);
        chk("midrst_dvo0", {15'd0, dvo0}, 16'd0);
        term(1'b1, 1'b1, 16'h3C00);
        idle(3);
        chk("midrst_pulses0", 16'(pulses0 - p0), 16'd1);
        check_lit("after_rst", 16'h3C00, 6'b100000, 16'd1);

        // reset while a result sits in the output register stage
        p1 = pulses1;
        term(1'b1, 1'b1, 16'h4000);
        beat(1'b1, 1'b0, 1'b0, 1'b0, 6'b001000, 16'd0);
        idle(3);
        chk("pipe_clear_pulses1", 16'(pulses1 - p1), 16'd0);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            rand_term(rp, rt);
            beat(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 25),
                 rt, rp);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
